traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor.sv | 86 ++++++++
 tb/tb_traffic_light_monitor.sv | 119 +++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: tracks the highway/farm light sequence and flags illegal codes, order and phase timing.
module traffic_light_monitor #(
  parameter int HY_CYC = 6,
  parameter int FG_CYC = 11,
  parameter int FY_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_HW,
  input  logic [2:0] light_FM,
  input  logic       fault_clr,
  output logic       locked,
  output logic [1:0] phase,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] cycle_cnt
);
  typedef enum logic {SYNC, TRACK} state_t;
  state_t state, state_n;
  logic [5:0] pair;
  logic       legal, err;
  logic [1:0] code, err_code, phase_n, fault_code_n;
  logic [7:0] dur_cnt, dur_n, cycle_n, lim;
  logic       fault_n;
  assign pair   = {light_HW, light_FM};
  assign legal  = pair inside {6'b100_001, 6'b010_001, 6'b001_100, 6'b001_010};
  assign code   = pair == 6'b010_001 ? 2'd1 : pair == 6'b001_100 ? 2'd2 : pair == 6'b001_010 ? 2'd3 : 2'd0;
  assign lim    = phase == 2'd1 ? 8'(HY_CYC) : phase == 2'd2 ? 8'(FG_CYC) : 8'(FY_CYC);
  assign locked = state == TRACK;
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    dur_n    = dur_cnt;
    cycle_n  = cycle_cnt;
    err      = 1'b0;
    err_code = 2'd0;
    if (state == SYNC) begin
      if (legal && code == 2'd0) begin
        state_n = TRACK;
        phase_n = 2'd0;
        dur_n   = 8'd1;
      end
    end else if (!legal) begin
      err      = 1'b1;
      err_code = 2'b01;
    end else if (code == phase) begin
      // phase 00 has no limit; others overrun once the limit is already reached
      if (phase != 2'd0 && dur_cnt >= lim) begin
        err      = 1'b1;
        err_code = 2'b11;
      end else dur_n = dur_cnt == 8'hff ? dur_cnt : dur_cnt + 8'd1;
    end else if (code == phase + 2'd1) begin
      if (phase != 2'd0 && dur_cnt < lim) begin
        err      = 1'b1;
        err_code = 2'b11;
      end else begin
        phase_n = code;
        dur_n   = 8'd1;
        cycle_n = phase == 2'd3 ? cycle_cnt + 8'd1 : cycle_cnt;
      end
    end else begin
      err      = 1'b1;
      err_code = 2'b10;
    end
    if (err) state_n = SYNC;
    fault_n      = err | (fault & ~fault_clr);
    fault_code_n = err && (!fault || fault_clr) ? err_code : fault_clr ? 2'd0 : fault_code;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SYNC;
      phase      <= 2'd0;
      dur_cnt    <= 8'd0;
      cycle_cnt  <= 8'd0;
      fault      <= 1'b0;
      fault_code <= 2'd0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      dur_cnt    <= dur_n;
      cycle_cnt  <= cycle_n;
      fault      <= fault_n;
      fault_code <= fault_code_n;
    end
  end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed vectors with hand-computed expectations for traffic_light_monitor.
module tb_traffic_light_monitor;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] light_HW = 3'b111;
  logic [2:0] light_FM = 3'b111;
  logic       fault_clr = 1'b0;
  logic       locked, fault;
  logic [1:0] phase, fault_code;
  logic [7:0] cycle_cnt;
  int total = 0, passed = 0;
  localparam logic [5:0] HG = 6'b100_001, HY = 6'b010_001, FG = 6'b001_100, FY = 6'b001_010, BAD = 6'b110_001;
  traffic_light_monitor dut (
    .clk(clk), .reset(reset), .light_HW(light_HW), .light_FM(light_FM), .fault_clr(fault_clr),
    .locked(locked), .phase(phase), .fault(fault), .fault_code(fault_code), .cycle_cnt(cycle_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic step(input logic [5:0] p, input logic clr = 1'b0);
    {light_HW, light_FM} = p;
    fault_clr = clr;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
  endtask
  task automatic hold(input logic [5:0] p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask
  task automatic full_cycle();
    hold(HY, 6);
    hold(FG, 11);
    hold(FY, 4);
    step(HG);
  endtask
  initial begin
    repeat (2) step(BAD);
    check("rst_locked", locked, 0);
    check("rst_phase", phase, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_cycle", cycle_cnt, 0);
    reset = 1'b0;
    step(HG);
    check("lock_first_hg", locked, 1);
    check("lock_phase", phase, 0);
    hold(HG, 2);
    step(HY);
    check("phase_hy", phase, 1);
    hold(HY, 5);
    step(FG);
    check("phase_fg", phase, 2);
    hold(FG, 10);
    step(FY);
    check("phase_fy", phase, 3);
    hold(FY, 3);
    step(HG);
    check("cycle_one", cycle_cnt, 1);
    check("cycle_fault", fault, 0);
    check("cycle_phase", phase, 0);
    for (int i = 0; i < 254; i++) full_cycle();
    check("cycle_255", cycle_cnt, 255);
    full_cycle();
    check("cycle_wrap", cycle_cnt, 0);
    check("wrap_locked", locked, 1);
    hold(HY, 6);
    check("hy6_ok", fault, 0);
    step(HY);
    check("overrun_fault", fault, 1);
    check("overrun_code", fault_code, 3);
    check("overrun_locked", locked, 0);
    step(HG);
    check("relock", locked, 1);
    hold(HY, 5);
    step(FG);
    check("underrun_locked", locked, 0);
    check("underrun_code_held", fault_code, 3);
    step(HG, 1'b1);
    check("clr_fault", fault, 0);
    check("clr_code", fault_code, 0);
    check("clr_cycle", cycle_cnt, 0);
    step(BAD);
    check("illegal_code", fault_code, 1);
    check("illegal_locked", locked, 0);
    step(BAD, 1'b1);
    step(BAD);
    check("sync_illegal_fault", fault, 0);
    check("sync_illegal_code", fault_code, 0);
    step(HG);
    step(FG);
    check("seq_code", fault_code, 2);
    check("seq_locked", locked, 0);
    step(HG);
    check("seq_relock", locked, 1);
    step(BAD, 1'b1);
    check("clr_new_fault", fault, 1);
    check("clr_new_code", fault_code, 1);
    step(HG, 1'b1);
    check("clr_alone_fault", fault, 0);
    check("clr_alone_code", fault_code, 0);
    check("clr_alone_cycle", cycle_cnt, 0);
    hold(HY, 3);
    reset = 1'b1;
    step(HY);
    reset = 1'b0;
    check("midrst_locked", locked, 0);
    check("midrst_phase", phase, 0);
    check("midrst_fault", fault, 0);
    step(HG);
    full_cycle();
    check("postrst_cycle", cycle_cnt, 1);
    check("postrst_fault", fault, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
